// File: rtl/peripheral_timer_regs.sv
// peripheral_timer_regs
// Four-register 32-bit down-counting timer with a prescaler, one-shot and
// auto-reload modes, a sticky expiry flag, a saturating expiry counter and a
// level interrupt. Register accesses arrive as one-hot write/read strobes from
// the bus adapter. Read data is presented per register, and the adapter muxes it.
//
// Register map
//   0 CTRL   : [0] enable, [1] auto_reload, [2] irq_en, [15:8] prescale
//   1 LOAD   : reload value
//   2 COUNT  : current count (a write loads it directly)
//   3 STATUS : [0] expired (W1C), [1] running (= enable),
//              [15:8] expire_cnt (saturating, cleared by a STATUS read)

module peripheral_timer_regs #(
    parameter int                    COUNTWIDTH    = 32,
    parameter int                    PRESCALEWIDTH = 8,
    parameter logic [COUNTWIDTH-1:0] RESETLOAD     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       write_en,
    input  logic [3:0]       read_en,
    input  logic [31:0]      data_in,
    output logic [3:0][31:0] data_out,
    output logic             irq
);

    localparam int REG_CTRL   = 0;
    localparam int REG_LOAD   = 1;
    localparam int REG_COUNT  = 2;
    localparam int REG_STATUS = 3;

    localparam logic [COUNTWIDTH-1:0]    COUNT_ONE = COUNTWIDTH'(32'd1);
    localparam logic [PRESCALEWIDTH-1:0] PRESC_ONE = PRESCALEWIDTH'(32'd1);
    localparam logic [7:0]               EXP_MAX   = 8'd255;

    // Control register fields
    logic                     enable_r;
    logic                     auto_reload_r;
    logic                     irq_en_r;
    logic [PRESCALEWIDTH-1:0] prescale_r;

    // Timer datapath state
    logic [PRESCALEWIDTH-1:0] presc_cnt_r;
    logic [COUNTWIDTH-1:0]    load_r;
    logic [COUNTWIDTH-1:0]    count_r;
    logic                     expired_r;
    logic [7:0]               expire_cnt_r;

    // Per-cycle events
    logic                     tick_s;
    logic                     expire_s;
    logic                     unused_s;

    // A tick fires when the running prescaler reaches the programmed divide value.
    // An expiry is a tick that lands on a zero count.
    assign tick_s   = enable_r & (presc_cnt_r == prescale_r);
    assign expire_s = tick_s & (count_r == '0);

    // Level interrupt taken straight from registered state, so it has no added latency
    assign irq = expired_r & irq_en_r;

    // Strobe and data bits that carry no function in this block
    assign unused_s = ^{read_en[2:0], data_in};

    // CTRL register: a bus write takes priority over the one-shot auto-stop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_r      <= 1'b0;
            auto_reload_r <= 1'b0;
            irq_en_r      <= 1'b0;
            prescale_r    <= '0;
        end else if (write_en[REG_CTRL]) begin
            enable_r      <= data_in[0];
            auto_reload_r <= data_in[1];
            irq_en_r      <= data_in[2];
            prescale_r    <= data_in[8 +: PRESCALEWIDTH];
        end else if (expire_s && !auto_reload_r) begin
            enable_r      <= 1'b0;
        end
    end

    // Prescale counter: held at 0 while disabled, so enabling always restarts it from 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt_r <= '0;
        end else if (!enable_r) begin
            presc_cnt_r <= '0;
        end else if (tick_s) begin
            presc_cnt_r <= '0;
        end else begin
            presc_cnt_r <= presc_cnt_r + PRESC_ONE;
        end
    end

    // LOAD register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_r <= RESETLOAD;
        end else if (write_en[REG_LOAD]) begin
            load_r <= data_in[COUNTWIDTH-1:0];
        end
    end

    // COUNT register: a bus write discards any decrement or reload from the same tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= RESETLOAD;
        end else if (write_en[REG_COUNT]) begin
            count_r <= data_in[COUNTWIDTH-1:0];
        end else if (tick_s) begin
            if (count_r != '0) begin
                count_r <= count_r - COUNT_ONE;
            end else if (auto_reload_r) begin
                count_r <= load_r;
            end
        end
    end

    // STATUS expired flag: a hardware set beats a simultaneous W1C
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expired_r <= 1'b0;
        end else if (expire_s) begin
            expired_r <= 1'b1;
        end else if (write_en[REG_STATUS] && data_in[0]) begin
            expired_r <= 1'b0;
        end
    end

    // STATUS expiry counter: saturates at 255. A read clears it, but an expiry
    // in the same cycle as the read is still counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expire_cnt_r <= 8'd0;
        end else if (read_en[REG_STATUS]) begin
            expire_cnt_r <= expire_s ? 8'd1 : 8'd0;
        end else if (expire_s && (expire_cnt_r != EXP_MAX)) begin
            expire_cnt_r <= expire_cnt_r + 8'd1;
        end
    end

    // Per-register read data, combinational from state; unused bits read 0
    always_comb begin
        data_out                                 = '0;
        data_out[REG_CTRL][0]                    = enable_r;
        data_out[REG_CTRL][1]                    = auto_reload_r;
        data_out[REG_CTRL][2]                    = irq_en_r;
        data_out[REG_CTRL][8 +: PRESCALEWIDTH]   = prescale_r;
        data_out[REG_LOAD][COUNTWIDTH-1:0]       = load_r;
        data_out[REG_COUNT][COUNTWIDTH-1:0]      = count_r;
        data_out[REG_STATUS][0]                  = expired_r;
        data_out[REG_STATUS][1]                  = enable_r;
        data_out[REG_STATUS][15:8]               = expire_cnt_r;
    end

endmodule

// File: doc/peripheral_timer_regs.md
Name: peripheral_timer_regs

Overview:
Downstream consumer of the Avalon register adapter's register-side bundle. It implements a 4-register, 32-bit down-counting timer peripheral with:
- a prescaler
- one-shot and auto-reload modes
- a sticky expiry flag and a saturating expiry counter
- a level interrupt output

Register writes and reads arrive as one-hot per-register strobes plus a shared write data word. Read data is presented as a per-register array, which the adapter muxes and pipelines.

Parameters:
- COUNTWIDTH, 32, width of the LOAD and COUNT registers; must be ≤ 32. Upper bits read as 0.
- PRESCALEWIDTH, 8, width of the CTRL prescale field; must be ≤ 8.
- RESETLOAD, 0, reset value of LOAD and COUNT.

Ports:
- clk  input  1  peripheral clock, driven from reg_io.clk
- reset  input  1  asynchronous, active-high reset, driven from reg_io.reset
- write_en  input  4  one-hot register write strobes; index = register address
- read_en  input  4  one-hot register read strobes; index = register address
- data_in  input  32  write data, valid in any cycle where a write_en bit is set
- data_out  output  4x32  per-register read data; element i = register i, combinational from state
- irq  output  1  level interrupt = STATUS.expired & CTRL.irq_en

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-high, and applies to all state. Reset values:
  - CTRL = 0
  - LOAD = COUNT = RESETLOAD
  - STATUS = 0, prescale counter = 0
  - irq = 0; data_out reflects these values
- Register map:
  - 0 CTRL (RW): [0] enable, [1] auto_reload, [2] irq_en, [15:8] prescale; other bits read 0.
  - 1 LOAD (RW): reload value.
  - 2 COUNT (RW): current count. A write loads COUNT directly.
  - 3 STATUS:
    - [0] expired: sticky, write-1-to-clear.
    - [1] running: RO, equals CTRL.enable.
    - [15:8] expire_cnt: saturates at 255, cleared by read_en[3].
    - Other bits read 0.
- Register writes: take effect on the clk edge in which write_en[i] = 1. Only the strobed register changes. More than one write_en bit set is illegal; behaviour is undefined and the bench does not drive it.
- Prescaler: while enable = 1, the prescale counter increments every cycle. When it equals CTRL.prescale, it wraps to 0 and generates a one-cycle tick. Consequences:
  - prescale = 0 gives a tick every cycle.
  - prescale = N gives a tick every N+1 cycles.
  - While enable = 0 the prescale counter is held at 0.
  - A CTRL write that sets enable from 0 to 1 restarts the prescaler at 0.
- On a tick:
  - If COUNT ≠ 0: COUNT ← COUNT − 1.
  - If COUNT = 0:
    - expired ← 1 and expire_cnt ← min(expire_cnt + 1, 255).
    - If auto_reload = 1, COUNT ← LOAD.
    - Otherwise COUNT stays 0 and CTRL.enable ← 0 (one-shot stop).
- Simultaneous events:
  - COUNT write and tick in the same cycle: the write wins; the tick's decrement or reload is discarded, but any expiry set still occurs.
  - STATUS W1C of expired and a hardware expiry in the same cycle: the set wins (expired = 1).
  - read_en[3] and an expiry in the same cycle: expire_cnt ← 1.
  - CTRL write and one-shot auto-clear of enable in the same cycle: the CTRL write wins.
- Read side: read_en only affects STATUS.expire_cnt. In the cycle read_en[3] = 1, data_out[3] shows the pre-clear value; the clear is visible from the next cycle.
- irq: a registered-state function with no extra latency; it drops the cycle after expired is cleared or irq_en is written to 0.
- Width: LOAD and COUNT keep only data_in[COUNTWIDTH-1:0]. The prescale field keeps only data_in[8 +: PRESCALEWIDTH].

Test Plan:
- Reset: assert reset mid-count (COUNT = 5, enable = 1) -> on that cycle, without waiting for an edge, COUNT = 0, CTRL = 0, irq = 0, data_out[3] = 0.
- One-shot:
  - Stimulus: LOAD write is not needed; write COUNT = 3, then CTRL = 0x0000_0005 (enable, irq_en, prescale 0).
  - Response: COUNT reads 2, 1, 0 on successive cycles. On the 4th tick, expired = 1, irq = 1, enable = 0. COUNT holds 0 thereafter.
- Auto-reload with prescale:
  - Stimulus: LOAD = 2, COUNT = 2, CTRL = 0x0000_0303 (enable, auto_reload, prescale 3).
  - Response: ticks every 4 cycles. Expiry every 12 cycles with COUNT reloaded to 2. After 3 expiries, STATUS = 0x0000_0303.
- W1C race: issue a STATUS write of 0x1 in the same cycle as an expiry -> expired stays 1. A later STATUS write of 0x1 with no expiry -> expired = 0 and irq = 0 next cycle.
- Read-clear: with expire_cnt = 7, pulse read_en[3] -> data_out[3][15:8] = 7 that cycle, 0 the next. Force 300 expiries -> expire_cnt saturates at 255.
- Write priority: write COUNT = 0x10 coincident with a tick at COUNT = 0 in auto-reload mode (LOAD = 9) -> COUNT = 0x10 and expired = 1.
